// File: rtl/aes_ctr_sequencer_if.sv
// Stream and AES-core handshake bundle for the CTR sequencer.
// master = sequencer side, slave = plaintext source / AES core / ciphertext sink.
interface aes_ctr_sequencer_if #(
  parameter int BLOCK_BITS = 128
) ();
  logic [BLOCK_BITS-1:0] pt_data;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [BLOCK_BITS-1:0] aes_in;
  logic                  aes_start;
  logic [BLOCK_BITS-1:0] aes_out;
  logic                  aes_out_valid;
  logic [BLOCK_BITS-1:0] ct_data;
  logic                  ct_valid;
  logic                  ct_ready;

  modport master (
    input  pt_data, pt_valid, aes_out, aes_out_valid, ct_ready,
    output pt_ready, aes_in, aes_start, ct_data, ct_valid
  );

  modport slave (
    output pt_data, pt_valid, aes_out, aes_out_valid, ct_ready,
    input  pt_ready, aes_in, aes_start, ct_data, ct_valid
  );
endinterface

// File: rtl/aes_ctr_sequencer.sv
// AES counter-mode sequencer: one keystream request per plaintext block, XOR, ciphertext stream out.
// Optional WAIT watchdog with sticky timeout_err: define AES_CTR_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for plaintext or cfg_load
// START   | one-cycle aes_start pulse with counter block on aes_in
// WAIT    | waiting for keystream from the AES core
// OUT     | ciphertext held on ct_data until ct_ready
module aes_ctr_sequencer #(
  parameter int BLOCK_BITS = 128,
  parameter int CTR_BITS   = 32
`ifdef AES_CTR_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [BLOCK_BITS-1:0] cfg_iv,
  input  logic                  cfg_load,
  aes_ctr_sequencer_if.master   bus,
  output logic [BLOCK_BITS-1:0] ctr_value,
  output logic [31:0]           blocks_done,
  output logic                  ctr_wrap
`ifdef AES_CTR_SEQ_TIMEOUT_EN
  , output logic                timeout_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t                state, state_nxt;
  logic [BLOCK_BITS-1:0] pt_q;
  logic [BLOCK_BITS-1:0] aes_in_q;
  logic [BLOCK_BITS-1:0] ct_q;
  logic [CTR_BITS-1:0]   ctr_lo_inc;
  logic                  accept;
  logic                  wdog_tc;

`ifdef AES_CTR_SEQ_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog;
  assign wdog_tc = (wdog == '0);
`else
  assign wdog_tc = 1'b0;
`endif

  assign ctr_lo_inc = ctr_value[CTR_BITS-1:0] + {{(CTR_BITS-1){1'b0}}, 1'b1};

  // pt_ready is forced low while reset is asserted so nothing is offered mid-reset
  assign bus.pt_ready  = aresetn && (state == S_IDLE) && !cfg_load && !ctr_wrap;
  assign accept        = bus.pt_ready && bus.pt_valid;
  assign bus.aes_start = (state == S_START);
  assign bus.aes_in    = aes_in_q;
  assign bus.ct_valid  = (state == S_OUT);
  assign bus.ct_data   = ct_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.aes_out_valid)  state_nxt = S_OUT;
        else if (wdog_tc)       state_nxt = S_IDLE;
      end
      S_OUT:   if (bus.ct_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      pt_q        <= '0;
      aes_in_q    <= '0;
      ct_q        <= '0;
      ctr_value   <= '0;
      ctr_wrap    <= 1'b0;
      blocks_done <= '0;
`ifdef AES_CTR_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            ctr_value   <= cfg_iv;
            ctr_wrap    <= 1'b0;
            blocks_done <= '0;
`ifdef AES_CTR_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end else if (accept) begin
            // counter is frozen outside WAIT, so capturing it here equals capturing it in START
            pt_q     <= bus.pt_data;
            aes_in_q <= ctr_value;
          end
        end
        S_START: begin
`ifdef AES_CTR_SEQ_TIMEOUT_EN
          wdog <= WDOG_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (bus.aes_out_valid) begin
            ct_q                      <= bus.aes_out ^ pt_q;
            ctr_value[CTR_BITS-1:0]   <= ctr_lo_inc;
            if (&ctr_value[CTR_BITS-1:0]) ctr_wrap <= 1'b1;
          end
`ifdef AES_CTR_SEQ_TIMEOUT_EN
          else if (wdog_tc) begin
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog - {{(WDOG_W-1){1'b0}}, 1'b1};
          end
`endif
        end
        S_OUT: begin
          if (bus.ct_ready) blocks_done <= blocks_done + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Self-checking bench for aes_ctr_sequencer: transaction-level CTR model, randomized traffic, directed corner cases.
module tb_aes_ctr_sequencer;
  localparam int BB = 128;
  localparam logic [127:0] IV   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT   = 128'h00001111222233334444555566667777;
  localparam logic [127:0] CT_B = 128'hcdbc18465587fc418a8a320879ae8fbc;
  localparam logic [95:0]  UP   = 96'h0123456789abcdef01234567;
  localparam int AES_LAT = 12;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [BB-1:0] cfg_iv = '0;
  logic          cfg_load = 1'b0;
  logic [BB-1:0] ctr_value;
  logic [31:0]   blocks_done;
  logic          ctr_wrap;
`ifdef AES_CTR_SEQ_TIMEOUT_EN
  logic          timeout_err;
  logic          m_terr = 1'b0;
`endif

  aes_ctr_sequencer_if #(.BLOCK_BITS(BB)) bus ();

  aes_ctr_sequencer dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cfg_iv      (cfg_iv),
    .cfg_load    (cfg_load),
    .bus         (bus.master),
    .ctr_value   (ctr_value),
    .blocks_done (blocks_done),
    .ctr_wrap    (ctr_wrap)
`ifdef AES_CTR_SEQ_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // transaction-level model state
  bit           busy = 1'b0;
  int           age = 0;
  logic [127:0] m_ctr = '0, m_ain = '0, m_ct = '0, last_ct = '0;
  logic         m_wrap = 1'b0;
  logic [31:0]  m_done = '0;
  int           start_cnt = 0;
  int           ctv_cnt = 0;
  logic [31:0]  ain_log[$];
  bit           aes_respond = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // AES core stand-in: keystream = ~counter block, AES_LAT cycles after aes_start
  initial begin
    int cnt = 0;
    logic [127:0] ks = '0;
    bus.aes_out_valid = 1'b0;
    bus.aes_out = '0;
    forever begin
      @(posedge aclk); #1;
      bus.aes_out_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.aes_out_valid = 1'b1;
          bus.aes_out = ks;
        end
      end
      @(negedge aclk);
      if (bus.aes_start && aes_respond) begin
        cnt = AES_LAT;
        ks = ~bus.aes_in;
      end
    end
  end

  // compare process: check everything against the model, then advance the model
  always @(negedge aclk) begin
    logic exp_start, exp_ctv;
    if (!aresetn) begin
      busy = 1'b0; age = 0; m_ctr = '0; m_wrap = 1'b0; m_done = '0;
`ifdef AES_CTR_SEQ_TIMEOUT_EN
      m_terr = 1'b0;
`endif
    end else begin
      exp_start = busy && (age == 1);
      exp_ctv   = busy && aes_respond && (age >= AES_LAT + 2);
      chk("blocks_done", 128'(blocks_done), 128'(m_done));
      chk("aes_start", 128'(bus.aes_start), 128'(exp_start));
      if (bus.aes_start) begin
        start_cnt++;
        ain_log.push_back(bus.aes_in[31:0]);
      end
      if (exp_start) chk("aes_in", bus.aes_in, m_ain);
      chk("ct_valid", 128'(bus.ct_valid), 128'(exp_ctv));
      if (bus.ct_valid) ctv_cnt++;
      if (exp_ctv) chk("ct_data", bus.ct_data, m_ct);
      if (!busy) begin
        chk("ctr_value", ctr_value, m_ctr);
        chk("ctr_wrap", 128'(ctr_wrap), 128'(m_wrap));
        chk("pt_ready_idle", 128'(bus.pt_ready), 128'(!cfg_load && !m_wrap));
`ifdef AES_CTR_SEQ_TIMEOUT_EN
        chk("timeout_err", 128'(timeout_err), 128'(m_terr));
`endif
      end else begin
        chk("pt_ready_busy", 128'(bus.pt_ready), 128'(0));
      end

      if (busy) begin
        if (exp_ctv && bus.ct_ready) begin
          busy = 1'b0;
          m_done = m_done + 32'd1;
          last_ct = bus.ct_data;
        end
`ifdef AES_CTR_SEQ_TIMEOUT_EN
        else if (!aes_respond && age == 65) begin
          busy = 1'b0;
          m_terr = 1'b1;
          m_ctr = m_ain;
          m_wrap = 1'b0;
        end
`endif
        else age++;
      end else if (cfg_load) begin
        m_ctr = cfg_iv; m_wrap = 1'b0; m_done = '0;
`ifdef AES_CTR_SEQ_TIMEOUT_EN
        m_terr = 1'b0;
`endif
      end else if (bus.pt_valid && !m_wrap) begin
        busy = 1'b1;
        age = 1;
        m_ain = m_ctr;
        m_ct = ~m_ctr ^ bus.pt_data;
        if (m_ctr[31:0] == 32'hffffffff) m_wrap = 1'b1;
        m_ctr[31:0] = m_ctr[31:0] + 32'd1;
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic load(input logic [127:0] v);
    cfg_iv = v; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] d);
    int n = 0;
    bus.pt_valid = 1'b1; bus.pt_data = d;
    @(negedge aclk);
    while (!bus.pt_ready && n < 300) begin @(negedge aclk); n++; end
    chk("accept", 128'(bus.pt_ready), 128'(1));
    step();
    bus.pt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin @(posedge aclk); n++; end
    chk("idle_reached", 128'(busy), 128'(0));
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s0, sc, cv, n;
    logic [127:0] held;
    bus.pt_valid = 1'b0; bus.pt_data = '0; bus.ct_ready = 1'b1;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ctr_value", ctr_value, 128'(0));
    chk("rst_aes_in", bus.aes_in, 128'(0));
    chk("rst_ct_data", bus.ct_data, 128'(0));
    chk("rst_ct_valid", 128'(bus.ct_valid), 128'(0));
    chk("rst_pt_ready", 128'(bus.pt_ready), 128'(0));
    chk("rst_blocks_done", 128'(blocks_done), 128'(0));
    step();
    aresetn = 1'b1;
    step();

    // basic single block
    load(IV);
    send(PT);
    wait_idle(200);
    chk("basic_ct", last_ct, CT_B);
    chk("basic_ctr_lo", 128'(ctr_value[31:0]), 128'(32'he0370735));
    chk("basic_done", 128'(blocks_done), 128'(1));
    chk("basic_starts", 128'(start_cnt), 128'(1));

    // three blocks back to back
    load(IV);
    s0 = ain_log.size();
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom, $urandom});
    wait_idle(200);
    chk("stream_starts", 128'(ain_log.size() - s0), 128'(3));
    for (int i = 0; i < 3; i++)
      if (s0 + i < ain_log.size()) chk("stream_ain_lo", 128'(ain_log[s0 + i]), 128'(32'he0370734 + i));
    chk("stream_done", 128'(blocks_done), 128'(3));

    // backpressure in OUT
    bus.ct_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    @(negedge aclk);
    while (!bus.ct_valid && n < 50) begin @(negedge aclk); n++; end
    chk("bp_ct_valid_seen", 128'(bus.ct_valid), 128'(1));
    held = bus.ct_data;
    @(posedge aclk);
    sc = start_cnt;
    repeat (20) begin
      @(negedge aclk);
      chk("bp_ct_hold", bus.ct_data, held);
      chk("bp_valid_hold", 128'(bus.ct_valid), 128'(1));
      chk("bp_pt_ready", 128'(bus.pt_ready), 128'(0));
    end
    step();
    bus.ct_ready = 1'b1;
    wait_idle(50);
    chk("bp_no_start", 128'(start_cnt), 128'(sc));
    chk("bp_done", 128'(blocks_done), 128'(4));

    // counter wrap
    load({UP, 32'hffffffff});
    send({$urandom, $urandom, $urandom, $urandom});
    wait_idle(200);
    chk("wrap_ctr", ctr_value, {UP, 32'h0});
    chk("wrap_flag", 128'(ctr_wrap), 128'(1));
    chk("wrap_done", 128'(blocks_done), 128'(1));
    sc = start_cnt;
    bus.pt_valid = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("wrap_pt_ready", 128'(bus.pt_ready), 128'(0));
    end
    step();
    bus.pt_valid = 1'b0;
    chk("wrap_no_start", 128'(start_cnt), 128'(sc));
    load(IV);
    @(negedge aclk);
    chk("wrap_cleared", 128'(ctr_wrap), 128'(0));
    step();

    // cfg_load beats pt_valid in the same cycle
    sc = start_cnt;
    cfg_iv = 128'h5555; cfg_load = 1'b1; bus.pt_valid = 1'b1; bus.pt_data = PT;
    @(negedge aclk);
    chk("prio_pt_ready", 128'(bus.pt_ready), 128'(0));
    step();
    cfg_load = 1'b0; bus.pt_valid = 1'b0;
    repeat (3) step();
    chk("prio_no_start", 128'(start_cnt), 128'(sc));
    chk("prio_loaded", ctr_value, 128'h5555);

    // reset during WAIT, late keystream must be ignored
    load(IV);
    send(PT);
    repeat (4) step();
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("mid_rst_ctr", ctr_value, 128'(0));
    chk("mid_rst_start", 128'(bus.aes_start), 128'(0));
    chk("mid_rst_ct_valid", 128'(bus.ct_valid), 128'(0));
    chk("mid_rst_done", 128'(blocks_done), 128'(0));
    step();
    aresetn = 1'b1;
    cv = ctv_cnt;
    repeat (20) step();
    chk("late_valid_ignored", 128'(ctv_cnt), 128'(cv));

`ifdef AES_CTR_SEQ_TIMEOUT_EN
    // watchdog: core never answers
    aes_respond = 1'b0;
    load(IV);
    send(PT);
    wait_idle(200);
    @(negedge aclk);
    chk("to_flag", 128'(timeout_err), 128'(1));
    chk("to_ctr", ctr_value, IV);
    chk("to_done", 128'(blocks_done), 128'(0));
    step();
    aes_respond = 1'b1;
    load(IV);
    @(negedge aclk);
    chk("to_cleared", 128'(timeout_err), 128'(0));
    step();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.pt_valid = ($urandom % 3) != 0;
      bus.pt_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.ct_ready = ($urandom % 4) != 0;
      cfg_load     = ($urandom % 40) == 0;
      case ($urandom % 3)
        0:       cfg_iv = {$urandom, $urandom, $urandom, 32'hffffffff};
        1:       cfg_iv = {$urandom, $urandom, $urandom, 32'hfffffffe};
        default: cfg_iv = {$urandom, $urandom, $urandom, $urandom};
      endcase
      step();
    end
    bus.pt_valid = 1'b0; cfg_load = 1'b0; bus.ct_ready = 1'b1;
    wait_idle(200);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
